square_arbiter: RTL and testbench
=================================

SQUARE_ARBITER -- requirements
Module: square_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; fixed at 4 for this revision.
REQ-002 Parameter OPW, default 2, operand width in bits; result width is 2*OPW (4).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  per-requester request; bit i high = requester i wants a square.
REQ-006 operand  input  8  packed operands; bits [2i+1:2i] = N of requester i.
REQ-007 grant  output  4  one-hot, registered; bit i high for exactly one cycle when requester i is accepted.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_id  output  2  index of the requester owning the result.
REQ-010 out_d  output  4  N*N of the granted operand.
REQ-011 out_ready  input  1  downstream accepts result when high with out_valid.

Function
REQ-012 The FSM SHALL have states IDLE, COMPUTE and HOLD.
REQ-013 In IDLE with req==0, the state, outputs and pointer SHALL remain unchanged.
REQ-014 In IDLE with req!=0, on the edge the FSM SHALL select the first set req bit at or after rr_ptr (wrapping 3->0), set grant to that one-hot, latch its operand and index, and enter COMPUTE.
REQ-015 In COMPUTE, on the edge the FSM SHALL clear grant, load out_d with the latched operand squared, load out_id, set out_valid, and enter HOLD.
REQ-016 Latency SHALL be: grant high in cycle k+1 and out_valid high from cycle k+2, where req is sampled in IDLE at edge k.
REQ-017 In HOLD, out_valid, out_id and out_d SHALL be held stable until an edge with out_ready high.
REQ-018 On an edge in HOLD with out_ready high, the FSM SHALL clear out_valid, set rr_ptr to (out_id+1) mod 4, and enter IDLE.
REQ-019 out_ready high in IDLE or COMPUTE SHALL have no effect.
REQ-020 req changes in COMPUTE or HOLD SHALL be ignored; a requester stays pending only by holding req high until it is granted.
REQ-021 An operand change after the grant edge SHALL NOT affect out_d.
REQ-022 Squaring SHALL be exact and unsigned: 0->0, 1->1, 2->4, 3->9 (out_d 0000, 0001, 0100, 1001).
REQ-023 At most one grant bit SHALL be high in any cycle, and grant SHALL be high only in COMPUTE.
REQ-024 Peak throughput SHALL be one result per 3 cycles when out_ready is held high.

Reset
REQ-025 While rst_n is low: state=IDLE, grant=0000, out_valid=0, out_id=00, out_d=0000, rr_ptr=0.
REQ-026 Reset asserted in COMPUTE or HOLD SHALL discard the in-flight result; no out_valid SHALL follow deassertion without a new grant.
REQ-027 The first arbitration after reset SHALL favour requester 0.

Structure
REQ-028 A shared package square_pkg SHALL hold NREQ, OPW, the state enumeration (IDLE, COMPUTE, HOLD) and the result width constant.
REQ-029 The squaring datapath SHALL be a combinational sub-module square_core (2-bit in, 4-bit out) instantiated once; the arbiter owns all registers.
REQ-030 Round-robin selection SHALL be a function or block local to square_arbiter.

Verification
REQ-031 Single request: req=0010, operand[3:2]=11, out_ready=1 -> grant=0010 for one cycle, then out_valid with out_id=1, out_d=1001.
REQ-032 Round robin: req=1111 held, out_ready=1 -> grant order 0001, 0010, 0100, 1000, 0001; results 3 cycles apart.
REQ-033 Backpressure: out_ready=0 for 5 cycles during HOLD -> out_valid, out_id and out_d stay stable with no new grant; one cycle after out_ready=1, state returns to IDLE.
REQ-034 Operand churn: operand changed the cycle after grant (N=2, then 0) -> out_d=0100.
REQ-035 Reset mid-HOLD: rst_n low for 1 cycle while out_valid=1 -> all outputs 0 immediately; next grant with req=1000 is 1000 (rr_ptr=0 start, wraps to 3).
REQ-036 Exhaustive values: each requester is driven through N=0..3 -> out_d matches REQ-022 for every id.

Source files
------------

// File: rtl/square_pkg.sv
// Shared constants and FSM state type for the round-robin squaring arbiter.
package square_pkg;

    localparam int NREQ = 4;
    localparam int OPW  = 2;
    localparam int RESW = 2 * OPW;
    localparam int IDW  = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/square_core.sv
// Combinational unsigned squarer for one latched operand.
module square_core
    import square_pkg::*;
(
    input  logic [OPW-1:0]  n,
    output logic [RESW-1:0] d
);

    logic [RESW-1:0] n_ext;

    assign n_ext = RESW'(n);
    assign d     = n_ext * n_ext;

endmodule

// File: rtl/square_arbiter.sv
// Round-robin arbiter granting one requester at a time a squared operand,
// with a held result under downstream backpressure.
module square_arbiter
    import square_pkg::*;
#(
    parameter int NREQ = square_pkg::NREQ,
    parameter int OPW  = square_pkg::OPW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*OPW-1:0]   operand,
    output logic [NREQ-1:0]       grant,
    output logic                  out_valid,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic [2*OPW-1:0]      out_d,
    input  logic                  out_ready
);

    localparam int IW = $clog2(NREQ);
    localparam int DW = 2 * OPW;

    state_t          state;
    state_t          state_nx;
    logic [NREQ-1:0] grant_nx;
    logic [OPW-1:0]  lat_op;
    logic [OPW-1:0]  lat_op_nx;
    logic [IW-1:0]   lat_id;
    logic [IW-1:0]   lat_id_nx;
    logic            valid_nx;
    logic [IW-1:0]   out_id_nx;
    logic [DW-1:0]   out_d_nx;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   ptr_nx;
    logic [IW-1:0]   pick;
    logic [DW-1:0]   sq;

    // First set request at or after p; index arithmetic wraps at NREQ.
    function automatic logic [IW-1:0] rr_pick(
        input logic [NREQ-1:0] r,
        input logic [IW-1:0]   p
    );
        logic [IW-1:0] idx;
        logic          found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = p + IW'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign pick = rr_pick(req, rr_ptr);

    square_core u_core (
        .n (lat_op),
        .d (sq)
    );

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        lat_op_nx = lat_op;
        lat_id_nx = lat_id;
        valid_nx  = out_valid;
        out_id_nx = out_id;
        out_d_nx  = out_d;
        ptr_nx    = rr_ptr;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    grant_nx  = NREQ'(1) << pick;
                    lat_op_nx = operand[int'(pick)*OPW +: OPW];
                    lat_id_nx = pick;
                    state_nx  = COMPUTE;
                end
            end
            COMPUTE: begin
                grant_nx  = '0;
                out_d_nx  = sq;
                out_id_nx = lat_id;
                valid_nx  = 1'b1;
                state_nx  = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    valid_nx = 1'b0;
                    ptr_nx   = out_id + IW'(1);
                    state_nx = IDLE;
                end
            end
            default: begin
                grant_nx = '0;
                valid_nx = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            lat_op    <= '0;
            lat_id    <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_d     <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            lat_op    <= lat_op_nx;
            lat_id    <= lat_id_nx;
            out_valid <= valid_nx;
            out_id    <= out_id_nx;
            out_d     <= out_d_nx;
            rr_ptr    <= ptr_nx;
        end
    end

endmodule

// File: tb/tb_square_arbiter.sv
// Bench for square_arbiter: directed table, corner sequences, random vs model.
module tb_square_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] operand;
    logic [3:0] grant;
    logic       out_valid;
    logic [1:0] out_id;
    logic [3:0] out_d;
    logic       out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    square_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .operand   (operand),
        .grant     (grant),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_d     (out_d),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference: phase 0 waiting, 1 granted, 2 result presented.
    int       m_phase;
    int       m_ptr;
    int       m_id;
    int       m_op;
    int       m_grant;
    int       m_valid;
    int       m_oid;
    int       m_d;
    int       sq_tab [4];

    typedef struct {
        logic [3:0] req;
        logic [7:0] op;
        logic       rdy;
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
        logic [3:0] d;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_id    = 0;
        m_op    = 0;
        m_grant = 0;
        m_valid = 0;
        m_oid   = 0;
        m_d     = 0;
    endtask

    task automatic model_edge();
        int idx;
        case (m_phase)
            0: if (req != 0) begin
                for (int j = 3; j >= 0; j--) begin
                    idx = (m_ptr + j) % 4;
                    if (req[idx]) m_id = idx;
                end
                m_grant = 1 << m_id;
                m_op    = (operand >> (2 * m_id)) & 3;
                m_phase = 1;
            end
            1: begin
                m_grant = 0;
                m_d     = m_op * m_op;
                m_oid   = m_id;
                m_valid = 1;
                m_phase = 2;
            end
            default: if (out_ready) begin
                m_valid = 0;
                m_ptr   = (m_oid + 1) % 4;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("grant", grant, m_grant);
        chk("grant_onehot", $countones(grant) <= 1, 1);
        chk("out_valid", out_valid, m_valid);
        if (m_valid != 0) begin
            chk("out_id", out_id, m_oid);
            chk("out_d", out_d, m_d);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_id", out_id, 0);
        chk("rst_d", out_d, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drive(input logic [3:0] r, input logic [7:0] o,
                         input logic rd);
        req       = r;
        operand   = o;
        out_ready = rd;
    endtask

    initial begin
        logic [7:0] op;
        sq_tab[0] = 0;
        sq_tab[1] = 1;
        sq_tab[2] = 4;
        sq_tab[3] = 9;
        tbl[0] = '{4'b0010, 8'h0C, 1'b1, 4'b0010, 1'b0, 2'd0, 4'd0};
        tbl[1] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 2'd1, 4'd9};
        tbl[2] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0};
        tbl[3] = '{4'b0001, 8'h02, 1'b0, 4'b0001, 1'b0, 2'd0, 4'd0};
        tbl[4] = '{4'b0000, 8'h00, 1'b0, 4'b0000, 1'b1, 2'd0, 4'd4};
        tbl[5] = '{4'b0000, 8'hFF, 1'b0, 4'b0000, 1'b1, 2'd0, 4'd4};
        tbl[6] = '{4'b1111, 8'hFF, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0};
        tbl[7] = '{4'b1111, 8'hFF, 1'b1, 4'b0010, 1'b0, 2'd0, 4'd0};
        tbl[8] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 2'd1, 4'd9};
        tbl[9] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0};

        rst_n = 1'b0;
        drive(4'b0, 8'h0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_grant", grant, 0);
        chk("init_valid", out_valid, 0);
        chk("init_id", out_id, 0);
        chk("init_d", out_d, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].req, tbl[i].op, tbl[i].rdy);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].v);
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d_id", i), out_id, tbl[i].id);
                chk($sformatf("tbl%0d_d", i), out_d, tbl[i].d);
            end
        end

        // Round robin with everyone requesting and no backpressure
        do_reset();
        drive(4'b1111, 8'hE4, 1'b1);
        for (int c = 0; c < 15; c++) begin
            step();
            if (c % 3 == 0)
                chk("rr_grant", grant, 1 << ((c / 3) % 4));
            else
                chk("rr_idle_grant", grant, 0);
            chk("rr_valid", out_valid, (c % 3 == 1) ? 1 : 0);
        end

        // Backpressure: result held, no new grant while stalled
        do_reset();
        drive(4'b0100, 8'h30, 1'b0);
        step();
        chk("bp_grant", grant, 4'b0100);
        drive(4'b1111, 8'h00, 1'b0);
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_id", out_id, 2);
            chk("bp_hold_d", out_d, 9);
            chk("bp_no_grant", grant, 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release", out_valid, 0);
        step();
        chk("bp_next_grant", grant, 4'b1000);

        // Reset while a result is presented
        do_reset();
        drive(4'b0010, 8'h04, 1'b0);
        step();
        req = 4'b0000;
        step();
        chk("mid_valid_before", out_valid, 1);
        do_reset();
        drive(4'b0000, 8'h00, 1'b1);
        step();
        step();
        chk("post_rst_no_valid", out_valid, 0);
        req = 4'b1000;
        step();
        chk("post_rst_grant", grant, 4'b1000);
        req = 4'b0000;
        step();
        step();

        // Every operand value through every requester
        for (int id = 0; id < 4; id++) begin
            for (int n = 0; n < 4; n++) begin
                op = 8'($urandom);
                op[2*id +: 2] = 2'(n);
                drive(4'(1 << id), op, 1'b1);
                step();
                drive(4'b0000, 8'($urandom), 1'b1);
                step();
                chk("exh_id", out_id, id);
                chk("exh_d", out_d, sq_tab[n]);
                step();
            end
        end

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 75) do_reset();
            drive(($urandom % 4 == 0) ? 4'b0 : 4'($urandom),
                  8'($urandom), ($urandom % 4) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
